// File: rtl/enemy_action_scheduler.sv
// Round-robin arbiter that grants one enemy at a time an attack or shield window,
// timed in frame ticks, with an optional post-attack cooldown and a game-over halt.
module enemy_action_scheduler #(
  parameter int N_ENEMY         = 4,
  parameter int ATTACK_FRAMES   = 30,
  parameter int SHIELD_FRAMES   = 20,
  parameter int COOLDOWN_FRAMES = 15
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       game_over,
  input  logic [3:0] dead,
  input  logic [3:0] atk_req,
  input  logic [3:0] shd_req,
  output logic [3:0] enemy_attack,
  output logic [3:0] enemy_shield,
  output logic       all_dead,
  output logic [1:0] active_id,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, ATTACK, SHIELD, COOLDOWN, HALT} state_t;

  state_t     state, state_next;
  logic [1:0] ptr, ptr_next;
  logic [7:0] cnt, cnt_next;
  logic [1:0] active_id_next;
  logic [3:0] attack_next, shield_next;
  logic       busy_next;
  logic       frame_clk_d;
  logic       tick;
  logic       found;
  logic [1:0] sel;

  assign tick = frame_clk & ~frame_clk_d;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= IDLE;
      ptr          <= 2'd0;
      cnt          <= 8'd0;
      frame_clk_d  <= 1'b0;
      enemy_attack <= 4'd0;
      enemy_shield <= 4'd0;
      all_dead     <= 1'b0;
      active_id    <= 2'd0;
      busy         <= 1'b0;
    end else begin
      state        <= state_next;
      ptr          <= ptr_next;
      cnt          <= cnt_next;
      frame_clk_d  <= frame_clk;
      enemy_attack <= attack_next;
      enemy_shield <= shield_next;
      all_dead     <= &dead;
      active_id    <= active_id_next;
      busy         <= busy_next;
    end
  end

  // First live requester at or after the round-robin pointer.
  always_comb begin
    logic [1:0] idx;
    found = 1'b0;
    sel   = 2'd0;
    idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && !dead[idx] && (atk_req[idx] | shd_req[idx])) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_comb begin
    state_next     = state;
    ptr_next       = ptr;
    cnt_next       = cnt;
    active_id_next = active_id;
    if (game_over && state != HALT) begin
      state_next = HALT;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            active_id_next = sel;
            ptr_next       = sel + 2'd1;
            if (atk_req[sel]) begin
              state_next = ATTACK;
              cnt_next   = 8'(ATTACK_FRAMES);
            end else begin
              state_next = SHIELD;
              cnt_next   = 8'(SHIELD_FRAMES);
            end
          end
        end
        ATTACK, SHIELD: begin
          // A death of the active enemy aborts straight to IDLE, even on a tick.
          if (dead[active_id]) begin
            state_next = IDLE;
          end else if (tick) begin
            if (cnt <= 8'd1) begin
              if (state == ATTACK && COOLDOWN_FRAMES != 0) begin
                state_next = COOLDOWN;
                cnt_next   = 8'(COOLDOWN_FRAMES);
              end else begin
                state_next = IDLE;
              end
            end else begin
              cnt_next = cnt - 8'd1;
            end
          end
        end
        COOLDOWN: begin
          if (tick) begin
            if (cnt <= 8'd1) state_next = IDLE;
            else             cnt_next   = cnt - 8'd1;
          end
        end
        HALT:    state_next = HALT;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    attack_next = 4'd0;
    shield_next = 4'd0;
    busy_next   = 1'b0;
    case (state_next)
      ATTACK: begin
        attack_next = 4'b0001 << active_id_next;
        busy_next   = 1'b1;
      end
      SHIELD: begin
        shield_next = 4'b0001 << active_id_next;
        busy_next   = 1'b1;
      end
      COOLDOWN: busy_next = 1'b1;
      default:  busy_next = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_enemy_action_scheduler.sv
// Directed bench: one instance with a 2-tick cooldown, one with no cooldown,
// both sharing stimulus; each check names the instance it observes.
module tb_enemy_action_scheduler;

  logic       Clk = 1'b0;
  logic       Reset, frame_clk, game_over;
  logic [3:0] dead, atk_req, shd_req;
  logic [3:0] attack_a, shield_a, attack_b, shield_b;
  logic       all_dead_a, all_dead_b, busy_a, busy_b;
  logic [1:0] id_a, id_b;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  enemy_action_scheduler #(.ATTACK_FRAMES(3), .SHIELD_FRAMES(2), .COOLDOWN_FRAMES(2)) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .game_over(game_over),
    .dead(dead), .atk_req(atk_req), .shd_req(shd_req),
    .enemy_attack(attack_a), .enemy_shield(shield_a), .all_dead(all_dead_a),
    .active_id(id_a), .busy(busy_a)
  );

  enemy_action_scheduler #(.ATTACK_FRAMES(3), .SHIELD_FRAMES(2), .COOLDOWN_FRAMES(0)) dut_nocd (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .game_over(game_over),
    .dead(dead), .atk_req(atk_req), .shd_req(shd_req),
    .enemy_attack(attack_b), .enemy_shield(shield_b), .all_dead(all_dead_b),
    .active_id(id_b), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      $error("check %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // One frame tick: a rising edge on frame_clk, then a low cycle so the next pulse re-arms.
  task automatic frame_tick();
    frame_clk = 1'b1;
    @(negedge Clk);
    frame_clk = 1'b0;
    @(negedge Clk);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    cycles(2);
    Reset = 1'b0;
  endtask

  initial begin
    logic [1:0] rr_order[5];
    logic [1:0] skip_order[4];
    rr_order   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    skip_order = '{2'd0, 2'd2, 2'd3, 2'd0};

    Reset = 1'b1; frame_clk = 1'b0; game_over = 1'b0;
    dead = 4'd0; atk_req = 4'd0; shd_req = 4'd0;
    cycles(2);
    check("rst_attack", 8'(attack_a), 8'h0);
    check("rst_shield", 8'(shield_a), 8'h0);
    check("rst_busy",   8'(busy_a),   8'h0);
    check("rst_id",     8'(id_a),     8'h0);
    check("rst_alldead", 8'(all_dead_a), 8'h0);
    Reset = 1'b0;
    cycles(1);

    // Single attack on id 0: 3-tick window then 2-tick cooldown.
    atk_req = 4'b0001;
    cycles(1);
    atk_req = 4'b0000;
    check("atk_grant",   8'(attack_a), 8'h1);
    check("atk_busy",    8'(busy_a),   8'h1);
    check("atk_id",      8'(id_a),     8'h0);
    frame_tick();
    frame_tick();
    check("atk_tick2",   8'(attack_a), 8'h1);
    frame_tick();
    check("atk_end",     8'(attack_a), 8'h0);
    check("cd_busy",     8'(busy_a),   8'h1);
    frame_tick();
    check("cd_busy1",    8'(busy_a),   8'h1);
    frame_tick();
    check("cd_done",     8'(busy_a),   8'h0);

    // Shield on id 2 only (pointer now at 1): exactly 2 ticks.
    shd_req = 4'b0100;
    cycles(1);
    shd_req = 4'b0000;
    check("shd_grant",   8'(shield_a), 8'h4);
    check("shd_id",      8'(id_a),     8'h2);
    frame_tick();
    check("shd_tick1",   8'(shield_a), 8'h4);
    frame_tick();
    check("shd_end",     8'(shield_a), 8'h0);
    check("shd_busy",    8'(busy_a),   8'h0);

    // Abort: id 2 dies on the same cycle as a tick.
    atk_req = 4'b0100;
    cycles(1);
    atk_req = 4'b0000;
    check("abort_grant", 8'(attack_a), 8'h4);
    frame_clk = 1'b1;
    dead = 4'b0100;
    cycles(1);
    check("abort_attack", 8'(attack_a), 8'h0);
    check("abort_busy",   8'(busy_a),   8'h0);
    frame_clk = 1'b0;
    dead = 4'b0000;
    cycles(2);
    check("abort_nocd",   8'(busy_a),   8'h0);

    // Reset mid-attack, then the next grant starts from id 0.
    atk_req = 4'b0100;
    cycles(1);
    atk_req = 4'b0000;
    check("rmid_grant",  8'(attack_a), 8'h4);
    Reset = 1'b1;
    cycles(1);
    check("rmid_attack", 8'(attack_a), 8'h0);
    check("rmid_busy",   8'(busy_a),   8'h0);
    Reset = 1'b0;
    atk_req = 4'b1111;
    cycles(1);
    atk_req = 4'b0000;
    check("rmid_regrant_id", 8'(id_a),     8'h0);
    check("rmid_regrant",    8'(attack_a), 8'h1);

    // Round robin with all requests held, no cooldown.
    do_reset();
    atk_req = 4'b1111;
    cycles(1);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("rr_id%0d", k),  8'(id_b),     8'(rr_order[k]));
      check($sformatf("rr_atk%0d", k), 8'(attack_b), 8'(4'b0001 << rr_order[k]));
      if (k < 4) begin
        frame_tick();
        frame_tick();
        frame_tick();
      end
    end
    atk_req = 4'b0000;

    // Dead id 1 is skipped.
    do_reset();
    dead = 4'b0010;
    atk_req = 4'b1111;
    cycles(1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("skip_id%0d", k), 8'(id_b), 8'(skip_order[k]));
      if (k < 3) begin
        frame_tick();
        frame_tick();
        frame_tick();
      end
    end
    atk_req = 4'b0000;

    // Everyone dead: flag rises one cycle later and nothing is granted.
    do_reset();
    dead = 4'b1111;
    atk_req = 4'b1111;
    check("alldead_pre", 8'(all_dead_b), 8'h0);
    cycles(1);
    check("alldead_set", 8'(all_dead_b), 8'h1);
    cycles(1);
    check("alldead_nogrant", 8'(attack_b), 8'h0);
    check("alldead_busy",    8'(busy_b),   8'h0);
    atk_req = 4'b0000;
    dead = 4'b0000;

    // Halt during a shield window.
    do_reset();
    shd_req = 4'b0001;
    cycles(1);
    shd_req = 4'b0000;
    check("halt_shd", 8'(shield_a), 8'h1);
    game_over = 1'b1;
    cycles(1);
    game_over = 1'b0;
    check("halt_shield", 8'(shield_a), 8'h0);
    check("halt_busy",   8'(busy_a),   8'h0);
    atk_req = 4'b1111;
    shd_req = 4'b1111;
    frame_tick();
    frame_tick();
    check("halt_ign_atk", 8'(attack_a), 8'h0);
    check("halt_ign_shd", 8'(shield_a), 8'h0);
    check("halt_ign_busy", 8'(busy_a),  8'h0);
    dead = 4'b1111;
    cycles(1);
    check("halt_alldead", 8'(all_dead_a), 8'h1);
    Reset = 1'b1;
    cycles(1);
    check("halt_rst_alldead", 8'(all_dead_a), 8'h0);
    dead = 4'b0000;
    Reset = 1'b0;
    cycles(1);
    check("halt_exit_grant", 8'(attack_a), 8'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
